// File: rtl/hazard_pkg.sv
// Shared scoreboard entry type, encodings and the youngest-hit priority
// function used by the pipeline hazard unit.
package hazard_pkg;

  localparam int SB_DEST_W = 8;
  localparam int MAX_DEPTH = 8;
  localparam int FWD_W     = 3;

  localparam logic [SB_DEST_W-1:0] REG_ZERO    = '0;
  localparam logic [FWD_W-1:0]     FWD_REGFILE = '0;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 regWrite;
    logic                 memRead;
  } sb_entry_t;

  // Lowest set bit wins: entry 0 is the youngest in-flight instruction.
  function automatic logic [FWD_W-1:0] youngest_hit(input logic [MAX_DEPTH-1:0] hits);
    logic [FWD_W-1:0] idx;
    idx = '0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (hits[i]) idx = FWD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source register against every scoreboard entry and reports
// whether it hits, whether the hit is a load in EX, and the youngest hit index.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3
) (
  input  sb_entry_t              entries [DEPTH],
  input  logic [REG_ADDR_W-1:0]  src,
  input  logic                   useSrc,
  output logic                   hit,
  output logic                   loadHit,
  output logic [FWD_W-1:0]       index
);

  logic [MAX_DEPTH-1:0] hitVec;
  logic                 srcLive;

  // Register 0 is hardwired, so it can never carry a dependency.
  assign srcLive = useSrc && (SB_DEST_W'(src) != REG_ZERO);

  for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_hit
    if (gi < DEPTH) begin : g_live
      assign hitVec[gi] = srcLive & entries[gi].valid & entries[gi].regWrite
                        & (entries[gi].dest == SB_DEST_W'(src));
    end else begin : g_pad
      assign hitVec[gi] = 1'b0;
    end
  end

  assign hit     = |hitVec;
  assign loadHit = hitVec[0] & entries[0].memRead;
  assign index   = youngest_hit(hitVec);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard-based hazard controller: ID stall, redirect flushes, forwarding
// selects and saturating counters. Define HAZARD_FORWARDING_EN to enable forwarding.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int DEPTH          = 3,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [FWD_W-1:0]      fwd_sel_a,
  output logic [FWD_W-1:0]      fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  sb_entry_t          sbReg [DEPTH];
  sb_entry_t          issueEntry;
  logic               hitA, hitB, loadHitA, loadHitB;
  logic [FWD_W-1:0]   idxA, idxB;
  logic               rawStall;
  logic [CNT_W-1:0]   stallCntReg, flushCntReg;

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) uMatchA (
    .entries(sbReg), .src(id_rs), .useSrc(id_use_rs),
    .hit(hitA), .loadHit(loadHitA), .index(idxA)
  );

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) uMatchB (
    .entries(sbReg), .src(id_rt), .useSrc(id_use_rt),
    .hit(hitB), .loadHit(loadHitB), .index(idxB)
  );

`ifdef HAZARD_FORWARDING_EN
  assign rawStall  = loadHitA | loadHitB;
  assign fwd_sel_a = hitA ? (idxA + FWD_W'(1)) : FWD_REGFILE;
  assign fwd_sel_b = hitB ? (idxB + FWD_W'(1)) : FWD_REGFILE;
`else
  // The WB entry writes through the regfile, so only younger entries stall.
  localparam logic [FWD_W-1:0] LAST_STALL_IDX = FWD_W'(DEPTH - 2);
  logic unusedLoadHits;
  assign unusedLoadHits = loadHitA ^ loadHitB;
  assign rawStall  = (hitA && (idxA <= LAST_STALL_IDX)) || (hitB && (idxB <= LAST_STALL_IDX));
  assign fwd_sel_a = FWD_REGFILE;
  assign fwd_sel_b = FWD_REGFILE;
`endif

  // Redirect beats stall; flushes are held quiet while reset is asserted.
  assign stall       = rawStall & ~redirect;
  assign flush_if_id = redirect & reset;
  assign flush_id_ex = redirect & reset;

  always_comb begin
    issueEntry = '0;
    if (id_valid && !stall && !redirect) begin
      issueEntry.valid    = 1'b1;
      issueEntry.dest     = SB_DEST_W'(id_dest);
      issueEntry.regWrite = id_reg_write;
      issueEntry.memRead  = id_mem_read;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sbReg[gi] <= '0;
        else        sbReg[gi] <= issueEntry;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                sbReg[gi] <= '0;
        else if (redirect && gi < REDIRECT_STAGE)  sbReg[gi] <= '0;
        else                                       sbReg[gi] <= sbReg[gi-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (stall && (stallCntReg != '1)) stallCntReg <= stallCntReg + CNT_W'(1);
      if (redirect && (flushCntReg != '1)) flushCntReg <= flushCntReg + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCntReg;
  assign flush_cnt = flushCntReg;

endmodule
